// File: rtl/bcd_serial_addsub_ctrl.sv
// Purpose : N-digit packed-BCD add/subtract sequencer that drives one shared digit adder, LSD first.
// Latency : DIGITS+1 cycles from the start cycle to done (2*DIGITS+1 for a negative sub with BCD_SIGNMAG_EN).
// Backpr. : start is accepted only in IDLE or DONE; a start while busy is dropped, nothing is queued.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   start, op, a, b   request, 0=A+B / 1=A-B, packed BCD operands (digit 0 in [3:0])
//   busy, done        operation in progress, one-cycle completion pulse
//   result, cout      packed BCD result, final decimal carry (sub: 1 means A >= B)
//   neg, err          negative sub result, an operand digit was > 9
//
// Optional feature macro: BCD_SIGNMAG_EN -- recomplement a negative difference into its magnitude.
module bcd_serial_addsub_ctrl #(
   parameter int DIGITS = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                op,
   input  logic [4*DIGITS-1:0] a,
   input  logic [4*DIGITS-1:0] b,
   output logic                busy,
   output logic                done,
   output logic [4*DIGITS-1:0] result,
   output logic                cout,
   output logic                neg,
   output logic                err
);

   localparam int IW = $clog2(DIGITS);

`ifdef BCD_SIGNMAG_EN
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_ADD = 2'd1, S_FIX = 2'd2, S_DONE = 2'd3} state_t;
`else
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_ADD = 2'd1, S_DONE = 2'd3} state_t;
`endif

   state_t              state, state_nxt;
   logic [4*DIGITS-1:0] a_q, b_q, result_q;
   logic                op_q, carry, cout_q, neg_q, err_q;
   logic [IW-1:0]       idx;

   logic                accept, in_bad, last;
   logic [3:0]          dig_a, dig_b, dsum;
   logic [4:0]          bin;
   logic                dcarry;

   assign accept = start && (state == S_IDLE || state == S_DONE);
   assign last   = (idx == IW'(DIGITS - 1));

   // Any digit of either incoming operand above 9 rejects the whole request.
   always_comb begin
      in_bad = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9) in_bad = 1'b1;
      end
   end

   // Shared digit adder. Subtraction feeds the 9's complement of B; the
   // recomplement pass feeds 9 - result digit against zero. The carry out of
   // the +6 correction is intentionally dropped by the 4-bit add.
   always_comb begin
      dig_a = a_q[4*idx +: 4];
      dig_b = op_q ? (4'd9 - b_q[4*idx +: 4]) : b_q[4*idx +: 4];
`ifdef BCD_SIGNMAG_EN
      if (state == S_FIX) begin
         dig_a = 4'd9 - result_q[4*idx +: 4];
         dig_b = 4'd0;
      end
`endif
      bin    = {1'b0, dig_a} + {1'b0, dig_b} + {4'b0000, carry};
      dcarry = 1'b0;
      dsum   = bin[3:0];
      if (bin > 5'd9) begin
         dsum   = bin[3:0] + 4'd6;
         dcarry = 1'b1;
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE, S_DONE: begin
            if (accept) state_nxt = in_bad ? S_DONE : S_ADD;
            else        state_nxt = S_IDLE;
         end
         S_ADD: begin
            if (last) begin
               state_nxt = S_DONE;
`ifdef BCD_SIGNMAG_EN
               if (op_q && !dcarry) state_nxt = S_FIX;
`endif
            end
         end
`ifdef BCD_SIGNMAG_EN
         S_FIX: begin
            if (last) state_nxt = S_DONE;
         end
`endif
         default: state_nxt = S_IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (state)
         S_ADD:   busy = 1'b1;
`ifdef BCD_SIGNMAG_EN
         S_FIX:   busy = 1'b1;
`endif
         S_DONE:  done = 1'b1;
         default: ;
      endcase
   end

   assign result = result_q;
   assign cout   = cout_q;
   assign neg    = neg_q;
   assign err    = err_q;

   // Operand latch, digit index, carry chain and result registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_q      <= '0;
         b_q      <= '0;
         op_q     <= 1'b0;
         idx      <= '0;
         carry    <= 1'b0;
         result_q <= '0;
         cout_q   <= 1'b0;
         neg_q    <= 1'b0;
         err_q    <= 1'b0;
      end else if (accept) begin
         a_q      <= a;
         b_q      <= b;
         op_q     <= op;
         idx      <= '0;
         carry    <= op;          // +1 turns the 9's complement into the 10's complement
         result_q <= '0;
         cout_q   <= 1'b0;
         neg_q    <= 1'b0;
         err_q    <= in_bad;
      end else if (state == S_ADD) begin
         result_q[4*idx +: 4] <= dsum;
         if (last) begin
            idx    <= '0;
            carry  <= op_q & ~dcarry;   // recomplement pass starts with carry-in 1
            cout_q <= dcarry;
            neg_q  <= op_q & ~dcarry;
         end else begin
            idx   <= idx + 1'b1;
            carry <= dcarry;
         end
      end
`ifdef BCD_SIGNMAG_EN
      else if (state == S_FIX) begin
         result_q[4*idx +: 4] <= dsum;
         if (last) begin
            idx   <= '0;
            carry <= 1'b0;
         end else begin
            idx   <= idx + 1'b1;
            carry <= dcarry;
         end
      end
`endif
   end

endmodule

// File: doc/bcd_serial_addsub_ctrl.md
# bcd_serial_addsub_ctrl

Multi-digit packed-BCD add/subtract sequencer that time-shares one single-digit BCD adder across all digits, processing one digit per clock, least significant first. It latches operands on a start/done handshake, generates the per-digit 9's complement and carry chain for subtraction, and flags invalid BCD input. It sits between a register-mapped or FSM-driven client and the shared BCD digit-adder datapath, and is the standard way to obtain N-digit decimal arithmetic without N adder copies.

## Interface
- `DIGITS`, default 4: number of BCD digits per operand, legal range 2..8.
- `clk` input 1: rising-edge clock.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: request; sampled only in IDLE or DONE.
- `op` input 1: 0 = A+B, 1 = A−B; latched with operands.
- `a` input 4*DIGITS: operand A, packed BCD, digit 0 in bits [3:0].
- `b` input 4*DIGITS: operand B, packed BCD.
- `busy` output 1: operation in progress.
- `done` output 1: one-cycle pulse; result/flags valid and held until next accepted start.
- `result` output 4*DIGITS: packed BCD result.
- `cout` output 1: final decimal carry. For add, overflow; for sub, 1 means A ≥ B.
- `neg` output 1: `op` & ~`cout`.
- `err` output 1: an operand digit was > 9.

## Operation
- States: IDLE, ADD, FIX (only with macro), DONE.
- IDLE/DONE + `start`: latch `a`, `b`, `op`. Check all 2*DIGITS digits for values > 9.
  - If any digit is invalid: go to DONE with `err`=1, `result`=0, `cout`=0, `neg`=0.
  - Otherwise: go to ADD with digit index 0. Carry-in is `op` (1 for sub, giving the 10's complement).
  - `err` clears on any accepted start that is valid.
- ADD: each cycle, digit i of A plus B′ plus carry goes to the shared digit adder.
  - B′ = B for add, 9 − B for sub.
  - Sum digit is written into `result[4i+3:4i]`. Carry is registered for digit i+1.
  - After digit DIGITS−1, the final carry goes to `cout`. Next state is DONE, or FIX when the macro is enabled and the result is negative.
- FIX: recomplement pass over `result`. Digit i becomes (9 − digit i) + carry, with carry-in 1, one digit per cycle, DIGITS cycles. Then go to DONE.
- DONE: `done`=1 for exactly one cycle. Next state is IDLE, or ADD/DONE if `start` is present.
- `start` in ADD or FIX is ignored (no queuing).
- Digit adder correction rule: binary sum > 9 → add 6, carry out 1. Intermediate width is 5 bits. Carry out of the correction stage is discarded.
- Reset mid-operation: at the next edge, go to IDLE and clear all outputs. The partial result is discarded.

## Timing
- Reset values: `busy`=0, `done`=0, `result`=0, `cout`=0, `neg`=0, `err`=0. State is IDLE, digit index 0, carry 0.
- `start` sampled at edge E:
  - `busy`=1 from E.
  - Digit i is registered at edge E+i+1.
  - `done`=1 in the cycle after edge E+DIGITS. Latency is DIGITS+1 cycles from the start cycle to the done cycle.
- FIX adds exactly DIGITS cycles.
- Invalid input: `done` is high in the cycle after E, and `busy` never rises.
- `busy` is 0 in the DONE cycle.
- `result`, `cout`, `neg` and `err` are updated only by the datapath or by an accepted start. They are stable from `done` until the next accepted start.
- Back-to-back operation: `start` held high during DONE is accepted in that cycle, so there is no idle gap.
- `rst` and `start` in the same cycle: `rst` wins.

## Configuration
- `BCD_SIGNMAG_EN` defined:
  - A negative subtraction runs FIX, and `result` holds the magnitude |A−B|.
  - `neg`=1, `cout`=0.
  - Latency is 2*DIGITS+1.
- `BCD_SIGNMAG_EN` undefined:
  - FIX state is absent.
  - A negative result is left as the raw 10's complement (10^DIGITS − |A−B|), with `neg`=1.
  - Latency is always DIGITS+1.

## Test plan
- Add 1234+5678 (DIGITS=4) → `result`=6912, `cout`=0, `neg`=0. `done` is 5 cycles after the start cycle; `busy` is high for 4 cycles.
- Add 9999+0001 → `result`=0000, `cout`=1. Carry must ripple through all four sequential steps.
- Sub 5000−1234 → `result`=3766, `cout`=1, `neg`=0, latency 5.
- Sub 1234−5000 → without macro: `result`=6234, `cout`=0, `neg`=1, latency 5. With `BCD_SIGNMAG_EN`: `result`=3766, `neg`=1, latency 9.
- `a`=0x00A0 with `start` → `done` the next cycle, `err`=1, `result`=0. A following valid start of 0001+0001 gives `result`=0002 and `err`=0.
- `start` pulsed in ADD cycle 2 → ignored, first result unchanged. `rst` asserted in ADD cycle 2 → all outputs 0 and state IDLE after the next edge, with no `done` pulse.
